// File: rtl/gabor_pkg.sv
// Shared types and default geometry for the Gabor filter pixel pipeline.
package gabor_pkg;

  localparam int PIXEL_WIDTH = 9;
  localparam int KERNEL_SIZE = 5;
  localparam int IMG_WIDTH   = 516;
  localparam int IMG_HEIGHT  = 516;

  typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t window_t [25];

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: single port, synchronous write, asynchronous read.
// Reading and writing the same address in one cycle returns the old contents.
module line_buffer #(
  parameter int DEPTH = 516,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; the contents have no reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 neighbourhood generator: raster pixels in, interior 5x5 windows out.
// Four line buffers hold the previous rows; a 5x5 shift register holds the live window.
module window_gen_5x5 #(
  parameter int PIXEL_WIDTH = gabor_pkg::PIXEL_WIDTH,
  parameter int IMG_WIDTH   = gabor_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = gabor_pkg::IMG_HEIGHT,
  parameter int KERNEL_SIZE = gabor_pkg::KERNEL_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [PIXEL_WIDTH-1:0] s_pixel,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [25*PIXEL_WIDTH-1:0]     m_window,
  output logic                          m_last
);

  localparam int WIN   = 25;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);

  generate
    if (KERNEL_SIZE != 5) begin : g_bad_kernel
      $error("window_gen_5x5: KERNEL_SIZE must be 5");
    end
    if (IMG_WIDTH < 5 || IMG_WIDTH > 4096 || IMG_HEIGHT < 5 || IMG_HEIGHT > 4096) begin : g_bad_size
      $error("window_gen_5x5: image dimensions must be within 5..4096");
    end
  endgenerate

  typedef logic signed [PIXEL_WIDTH-1:0] pix_t;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   accept;
  logic                   emit;
  logic                   col_end;
  logic                   row_end;
  logic [PIXEL_WIDTH-1:0] lb_q  [4];
  logic [PIXEL_WIDTH-1:0] lb_wd [4];
  pix_t                   col_in  [5];
  pix_t                   win_p0  [WIN];
  pix_t                   win_nxt [WIN];

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready && !clear;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  assign emit    = (row >= ROW_FIRST) && (col >= COL_FIRST);

  // Row cascade: each buffer takes the old contents of the one below it.
  always_comb begin
    lb_wd[0] = s_pixel;
    lb_wd[1] = lb_q[0];
    lb_wd[2] = lb_q[1];
    lb_wd[3] = lb_q[2];
  end

  for (genvar i = 0; i < 4; i++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIXEL_WIDTH)
    ) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb_wd[i]),
      .rdata (lb_q[i])
    );
  end

  // New rightmost column (oldest row on top) and the left-shifted window.
  always_comb begin
    col_in[0] = pix_t'(lb_q[3]);
    col_in[1] = pix_t'(lb_q[2]);
    col_in[2] = pix_t'(lb_q[1]);
    col_in[3] = pix_t'(lb_q[0]);
    col_in[4] = s_pixel;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        win_nxt[k*5+j] = win_p0[k*5+j+1];
      end
      win_nxt[k*5+4] = col_in[k];
    end
  end

  // Stage p0: window shift register, advanced on every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) win_p0 <= win_nxt;
  end

  // Stage p1: raster counters, output register and handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_window <= '0;
    end else if (clear) begin
      row     <= '0;
      col     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      m_valid <= emit;
      m_last  <= emit && row_end && col_end;
      if (emit) begin
        for (int n = 0; n < WIN; n++) begin
          m_window[n*PIXEL_WIDTH +: PIXEL_WIDTH] <= win_nxt[n];
        end
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x8 image with pixel(r,c) = r*8+c (+ frame offset).
module tb_window_gen_5x5;

  localparam int PW = 9;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int WV = 25*PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_pixel;
  logic          m_valid;
  logic          m_ready;
  logic [WV-1:0] m_window;
  logic          m_last;

  int            checks = 0;
  int            errors = 0;
  int            last_cnt;
  logic [WV-1:0] cap [32];

  window_gen_5x5 #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pixel  (s_pixel),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_window (m_window),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int p, input int step);
    return PW'((p % 64) + (p / 64) * step);
  endfunction

  // Window k (0..15) of a frame: pixelN = image(r-4+(N-1)/5, c-4+(N-1)%5), r=4+k/4, c=4+k%4
  function automatic logic [WV-1:0] exp_win(input int off, input int k);
    logic [WV-1:0] v;
    v = '0;
    for (int n = 0; n < 25; n++) begin
      v[n*PW +: PW] = PW'(off + (k/4 + n/5) * 8 + (k%4 + n%5));
    end
    return v;
  endfunction

  // Streams pixels 0..stop_p-1 and consumes windows until stop_w have been checked.
  // When stall_w >= 0, m_ready is held low at that window and the task returns at the
  // falling edge where that window is stalled.
  task automatic stream(input int step, input int vgap, input int rgap,
                        input int stop_p, input int stop_w, input int stall_w);
    int p = 0;
    int w = 0;
    int cyc = 0;
    bit hp = 0;
    bit pacc = 0;
    bit prdy = 0;
    bit pst = 0;
    logic [WV-1:0] pwin = '0;
    logic plast = 1'b0;
    while (!(p == stop_p && w == stop_w)) begin
      if (cyc > 3000) begin
        check("timeout", 1, 0);
        return;
      end
      cyc++;
      m_ready = (w == stall_w) ? 1'b0 : ($urandom_range(99) >= rgap);
      if (p < stop_p && $urandom_range(99) >= vgap) begin
        s_valid = 1'b1;
        s_pixel = pix(p, step);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (hp && !pacc && prdy) check("idle_drop", m_valid, 0);
      if (pst) begin
        check("hold_valid", m_valid, 1);
        check("hold_win", m_window, pwin);
        check("hold_last", m_last, plast);
      end
      if (m_valid && !m_ready) check("stall_sready", s_ready, 0);
      if (w == stall_w && m_valid) return;
      if (m_valid && m_ready) begin
        check("win", m_window, exp_win((w / 16) * step, w % 16));
        check("last", m_last, (w % 16) == 15);
        if (w < 32) cap[w] = m_window;
        if (m_last) last_cnt++;
        w++;
      end
      pacc = s_valid && s_ready;
      if (pacc) p++;
      prdy = m_ready;
      pst = m_valid && !m_ready;
      pwin = m_window;
      plast = m_last;
      hp = 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_check();
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("drain_idle", m_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_pixel = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_win", m_window, 0);
    check("rst_sready", s_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: continuous stream, always ready
    last_cnt = 0;
    stream(0, 0, 0, 64, 16, -1);
    check("t1_first_p1", cap[0][0 +: PW], 0);
    check("t1_first_p13", cap[0][12*PW +: PW], 18);
    check("t1_first_p25", cap[0][24*PW +: PW], 36);
    check("t1_last_p1", cap[15][0 +: PW], 27);
    check("t1_last_p25", cap[15][24*PW +: PW], 63);
    check("t1_last_cnt", last_cnt, 1);
    drain_check();

    // 2: random backpressure
    last_cnt = 0;
    stream(0, 0, 30, 64, 16, -1);
    check("t2_last_cnt", last_cnt, 1);
    drain_check();

    // 3: random input gaps
    last_cnt = 0;
    stream(0, 50, 0, 64, 16, -1);
    check("t3_last_cnt", last_cnt, 1);
    drain_check();

    // 4: two frames back to back, second frame offset by 100
    last_cnt = 0;
    stream(100, 0, 0, 128, 32, -1);
    check("t4_f2_p1", cap[16][0 +: PW], 100);
    check("t4_f2_p25", cap[16][24*PW +: PW], 136);
    check("t4_last_cnt", last_cnt, 2);
    drain_check();

    // 5: clear together with pixel (5,2), then a fresh frame
    stream(0, 0, 0, 42, 4, -1);
    s_valid = 1'b1;
    s_pixel = pix(42, 0);
    clear   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("t5_clr_valid", m_valid, 0);
    check("t5_clr_last", m_last, 0);
    @(posedge clk);
    #1;
    last_cnt = 0;
    stream(0, 0, 0, 64, 16, -1);
    check("t5_last_cnt", last_cnt, 1);
    drain_check();

    // 6: asynchronous reset while stalled at window 7, then a full frame
    stream(0, 0, 0, 64, 16, 6);
    check("t6_stalled", m_valid, 1);
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_last", m_last, 0);
    check("t6_rst_win", m_window, 0);
    check("t6_rst_sready", s_ready, 1);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rel_sready", s_ready, 1);
    last_cnt = 0;
    stream(0, 0, 0, 64, 16, -1);
    check("t6_f_p1", cap[0][0 +: PW], 0);
    check("t6_last_cnt", last_cnt, 1);
    drain_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
